// File: rtl/rsa256_wrapper.sv
// Avalon-MM master linking the effector core to a UART host link.
// Optional macro RSA_WRAPPER_CHECKSUM_EN adds XOR checksums on RX and TX.
module rsa256_wrapper (
    input  logic         avm_clk,
    input  logic         avm_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    input  logic [127:0] freqs,
    output logic [15:0]  threshold_gate,
    output logic [15:0]  threshold_camp,
    output logic [4:0]   ratio,
    output logic [15:0]  makeup
);

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;
    localparam int         RX_OK_BIT   = 7;
    localparam int         TX_OK_BIT   = 6;
    localparam int         N_RX        = 7;
    localparam int         N_TX        = 16;

`ifdef RSA_WRAPPER_CHECKSUM_EN
    localparam int RX_LEN = N_RX + 1;
    localparam int TX_LEN = N_TX + 1;
    localparam int PKT_W  = 56;
`else
    localparam int RX_LEN = N_RX;
    localparam int TX_LEN = N_TX;
    localparam int PKT_W  = 48;
`endif

    typedef enum logic [1:0] {
        S_QRX,
        S_RX,
        S_QTX,
        S_TX
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [4:0]   cnt;
    logic [PKT_W-1:0] pkt;
    logic [127:0] shreg;
    logic [7:0]   rx_byte;
    logic [7:0]   tx_byte;
    logic [55:0]  pkt_full;
    logic         done;
    logic         rx_last;
    logic         tx_last;
    logic         commit;
    logic         unused_bits;

    assign rx_byte = avm_readdata[7:0];
    assign done    = !avm_waitrequest;
    assign rx_last = (state == S_RX) && done
                     && (cnt == 5'(RX_LEN - 1));
    assign tx_last = (state == S_TX) && done
                     && (cnt == 5'(TX_LEN - 1));

`ifdef RSA_WRAPPER_CHECKSUM_EN
    logic [7:0] rx_xor;
    logic [7:0] tx_xor;

    // The 8th byte is the checksum; pkt already holds bytes 1..7.
    assign pkt_full = pkt;
    assign commit   = rx_last && (rx_byte == rx_xor);
    assign tx_byte  = (cnt == 5'(N_TX)) ? tx_xor : shreg[127:120];
`else
    // The final byte is still on the bus at the commit edge.
    assign pkt_full = {pkt, rx_byte};
    assign commit   = rx_last;
    assign tx_byte  = shreg[127:120];
`endif

    assign unused_bits = ^{avm_readdata[31:8], pkt_full[55],
                           pkt_full[39], pkt_full[23:21]};

    // State register.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state <= S_QRX;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and bus strobes; strobes depend on state only,
    // so they stay stable for the whole stalled access.
    always_comb begin
        state_nx      = state;
        avm_address   = STATUS_BASE;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = {24'd0, tx_byte};
        unique case (state)
            S_QRX: begin
                avm_read    = 1'b1;
                avm_address = STATUS_BASE;
                if (done && avm_readdata[RX_OK_BIT]) begin
                    state_nx = S_RX;
                end
            end
            S_RX: begin
                avm_read    = 1'b1;
                avm_address = RX_BASE;
                if (done) begin
                    state_nx = commit ? S_QTX : S_QRX;
                end
            end
            S_QTX: begin
                avm_read    = 1'b1;
                avm_address = STATUS_BASE;
                if (done && avm_readdata[TX_OK_BIT]) begin
                    state_nx = S_TX;
                end
            end
            S_TX: begin
                avm_write   = 1'b1;
                avm_address = TX_BASE;
                if (done) begin
                    state_nx = tx_last ? S_QRX : S_QTX;
                end
            end
            default: begin
                state_nx = S_QRX;
            end
        endcase
    end

    // Packet assembly, parameter commit and TX shifting.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            cnt            <= 5'd0;
            pkt            <= '0;
            shreg          <= 128'd0;
            threshold_gate <= 16'd0;
            threshold_camp <= 16'd0;
            ratio          <= 5'd1;
            makeup         <= 16'd0;
`ifdef RSA_WRAPPER_CHECKSUM_EN
            rx_xor         <= 8'd0;
            tx_xor         <= 8'd0;
`endif
        end else begin
            if (state == S_RX && done) begin
                pkt <= {pkt[PKT_W-9:0], rx_byte};
                cnt <= rx_last ? 5'd0 : cnt + 5'd1;
`ifdef RSA_WRAPPER_CHECKSUM_EN
                rx_xor <= rx_last ? 8'd0 : (rx_xor ^ rx_byte);
`endif
            end
            if (commit) begin
                threshold_gate <= {1'b0, pkt_full[54:40]};
                threshold_camp <= {1'b0, pkt_full[38:24]};
                ratio          <= (pkt_full[20:16] == 5'd0)
                                  ? 5'd1 : pkt_full[20:16];
                makeup         <= {1'b0, pkt_full[14:0]};
                shreg          <= freqs;
`ifdef RSA_WRAPPER_CHECKSUM_EN
                tx_xor         <= 8'd0;
`endif
            end
            if (state == S_TX && done) begin
                shreg <= {shreg[119:0], 8'h00};
                cnt   <= tx_last ? 5'd0 : cnt + 5'd1;
`ifdef RSA_WRAPPER_CHECKSUM_EN
                tx_xor <= tx_xor ^ tx_byte;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rsa256_wrapper.sv
// Directed bench for rsa256_wrapper with a small UART slave model.
// Honors RSA_WRAPPER_CHECKSUM_EN to match the DUT build.
module tb_rsa256_wrapper;

`ifdef RSA_WRAPPER_CHECKSUM_EN
    localparam int TXN = 17;
`else
    localparam int TXN = 16;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   addr;
    logic         rd;
    logic [31:0]  readdata;
    logic         wr;
    logic [31:0]  wd;
    logic         waitreq;
    logic [127:0] freqs = 128'd0;
    logic [15:0]  gate;
    logic [15:0]  camp;
    logic [4:0]   ratio;
    logic [15:0]  makeup;

    int total = 0;
    int bad = 0;

    logic [7:0] rx_mem [0:255];
    int         rx_len = 0;
    int         rx_idx = 0;
    logic [7:0] tx_log [0:255];
    int         tx_n = 0;
    logic       tx_ok = 1'b0;
    logic       stall_en = 1'b0;
    int         wcnt = 0;
    int         addr_bad = 0;
    int         stable_bad = 0;
    int         rw_bad = 0;
    logic [4:0] p_addr = 5'd0;
    logic       p_rd = 1'b0;
    logic       p_wr = 1'b0;
    logic [31:0] p_wd = 32'd0;
    logic       p_stall = 1'b0;

    localparam logic [127:0] F1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] F2 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

    rsa256_wrapper dut (
        .avm_clk         (clk),
        .avm_rst         (rst_n),
        .avm_address     (addr),
        .avm_read        (rd),
        .avm_readdata    (readdata),
        .avm_write       (wr),
        .avm_writedata   (wd),
        .avm_waitrequest (waitreq),
        .freqs           (freqs),
        .threshold_gate  (gate),
        .threshold_camp  (camp),
        .ratio           (ratio),
        .makeup          (makeup)
    );

    always #5 clk = ~clk;

    assign waitreq = stall_en && (rd || wr) && (wcnt < 5);

    // UART register file: junk in the upper bits the DUT must ignore.
    always_comb begin
        readdata = 32'hA5A5A500;
        if (addr == 5'd8) begin
            readdata[7] = (rx_idx < rx_len);
            readdata[6] = tx_ok;
        end else if (addr == 5'd0) begin
            readdata[7:0] = rx_mem[rx_idx[7:0]];
        end
    end

    // Bus monitor: completes transfers and checks stall stability.
    always @(posedge clk) begin
        if (rst_n) begin
            if (p_stall && ({addr, rd, wr, wd} !== {p_addr, p_rd, p_wr, p_wd}))
                stable_bad <= stable_bad + 1;
            if (rd && wr)
                rw_bad <= rw_bad + 1;
            p_stall <= waitreq;
            p_addr  <= addr;
            p_rd    <= rd;
            p_wr    <= wr;
            p_wd    <= wd;
            if ((rd || wr) && waitreq)
                wcnt <= wcnt + 1;
            if ((rd || wr) && !waitreq) begin
                wcnt <= 0;
                if (rd && addr == 5'd0)
                    rx_idx <= rx_idx + 1;
                if (wr) begin
                    if (addr != 5'd4)
                        addr_bad <= addr_bad + 1;
                    tx_log[tx_n[7:0]] <= wd[7:0];
                    tx_n <= tx_n + 1;
                end
            end
        end else begin
            p_stall <= 1'b0;
            wcnt    <= 0;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        rx_mem[rx_len[7:0]] = b;
        rx_len = rx_len + 1;
    endtask

    task automatic load_pkt(input logic [55:0] p);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < 7; i++) begin
            x = x ^ p[55-8*i -: 8];
            push_byte(p[55-8*i -: 8]);
        end
`ifdef RSA_WRAPPER_CHECKSUM_EN
        push_byte(x);
`endif
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int target);
        int i;
        i = 0;
        while (rx_idx < target && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic wait_tx(input int target);
        int i;
        i = 0;
        while (tx_n < target && i < 5000) begin
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({gate, camp, ratio, makeup} !== {16'd0, 16'd0, 5'd1, 16'd0}) begin
            bad++;
            $display("FAIL reset_params got %h/%h/%h/%h want 0/0/1/0",
                     gate, camp, ratio, makeup);
        end
        total++;
        if ({rd, wr, addr} !== {1'b1, 1'b0, 5'd8}) begin
            bad++;
            $display("FAIL reset_bus got rd=%b wr=%b addr=%0d want 1 0 8",
                     rd, wr, addr);
        end
        rst_n = 1'b1;
        cycles(4);
        total++;
        if ({rd, wr, addr} !== {1'b1, 1'b0, 5'd8} || rx_idx != 0) begin
            bad++;
            $display("FAIL idle_poll got rd=%b wr=%b addr=%0d rx=%0d want 1 0 8 0",
                     rd, wr, addr, rx_idx);
        end
    endtask

    task automatic test_param_load;
        freqs = F1;
        tx_ok = 1'b0;
        load_pkt(56'h006401F4041000);
        wait_rx(rx_len - 1);
        total++;
        if (gate !== 16'd0 || rx_idx != rx_len - 1) begin
            bad++;
            $display("FAIL early_commit got gate=%0d rx=%0d want 0 %0d",
                     gate, rx_idx, rx_len - 1);
        end
        wait_rx(rx_len);
        total++;
        if ({gate, camp, ratio, makeup} !== {16'd100, 16'd500, 5'd4, 16'd4096}) begin
            bad++;
            $display("FAIL param_load got %0d/%0d/%0d/%0d want 100/500/4/4096",
                     gate, camp, ratio, makeup);
        end
        cycles(5);
        total++;
        if (tx_n != 0 || {rd, wr, addr} !== {1'b1, 1'b0, 5'd8}) begin
            bad++;
            $display("FAIL tx_wait got writes=%0d rd=%b addr=%0d want 0 1 8",
                     tx_n, rd, addr);
        end
    endtask

    task automatic check_stream(input int base, input logic [127:0] ef,
                                input string tag);
        logic [7:0] x;
        logic [7:0] e;
        x = 8'd0;
        for (int i = 0; i < TXN; i++) begin
            if (i < 16) begin
                e = ef[127-8*i -: 8];
                x = x ^ e;
            end else begin
                e = x;
            end
            total++;
            if (tx_log[(base + i) % 256] !== e) begin
                bad++;
                $display("FAIL %s_byte%0d got %h want %h",
                         tag, i, tx_log[(base + i) % 256], e);
            end
        end
    endtask

    task automatic test_tx_stream;
        int base;
        base = tx_n;
        freqs = ~F1;
        tx_ok = 1'b1;
        wait_tx(base + TXN);
        total++;
        if (tx_n != base + TXN) begin
            bad++;
            $display("FAIL tx_count got %0d want %0d", tx_n - base, TXN);
        end
        check_stream(base, F1, "tx");
        cycles(10);
        total++;
        if (tx_n != base + TXN || addr_bad != 0
            || {rd, wr, addr} !== {1'b1, 1'b0, 5'd8}) begin
            bad++;
            $display("FAIL tx_end got n=%0d addr_bad=%0d addr=%0d want %0d 0 8",
                     tx_n - base, addr_bad, addr, TXN);
        end
        total++;
        if ({gate, ratio} !== {16'd100, 5'd4}) begin
            bad++;
            $display("FAIL param_hold got %0d/%0d want 100/4", gate, ratio);
        end
    endtask

    task automatic test_stall;
        int base;
        base = tx_n;
        stall_en = 1'b1;
        tx_ok = 1'b1;
        freqs = F2;
        load_pkt(56'h00C803E8082000);
        wait_tx(base + TXN);
        total++;
        if ({gate, camp, ratio, makeup} !== {16'd200, 16'd1000, 5'd8, 16'd8192}) begin
            bad++;
            $display("FAIL stall_params got %0d/%0d/%0d/%0d want 200/1000/8/8192",
                     gate, camp, ratio, makeup);
        end
        check_stream(base, F2, "stall");
        cycles(40);
        total++;
        if (tx_n != base + TXN || rx_idx != rx_len) begin
            bad++;
            $display("FAIL stall_once got tx=%0d rx=%0d want %0d %0d",
                     tx_n - base, rx_idx, TXN, rx_len);
        end
        total++;
        if (stable_bad != 0 || rw_bad != 0) begin
            bad++;
            $display("FAIL stall_stable got unstable=%0d rw=%0d want 0 0",
                     stable_bad, rw_bad);
        end
        stall_en = 1'b0;
    endtask

    task automatic test_clamp;
        int base;
        tx_ok = 1'b0;
        load_pkt(56'hFFFF9234E08005);
        wait_rx(rx_len);
        total++;
        if ({gate, camp, ratio, makeup} !== {16'h7FFF, 16'h1234, 5'd1, 16'h0005}) begin
            bad++;
            $display("FAIL clamp got %h/%h/%0d/%h want 7fff/1234/1/0005",
                     gate, camp, ratio, makeup);
        end
        base = tx_n;
        tx_ok = 1'b1;
        wait_tx(base + TXN);
        cycles(10);
        total++;
        if (tx_n != base + TXN) begin
            bad++;
            $display("FAIL clamp_drain got %0d want %0d", tx_n - base, TXN);
        end
    endtask

`ifdef RSA_WRAPPER_CHECKSUM_EN
    task automatic test_checksum;
        int base;
        logic [55:0] p;
        logic [7:0] x;
        p = 56'h000A0014020003;
        x = 8'd0;
        for (int i = 0; i < 7; i++) begin
            x = x ^ p[55-8*i -: 8];
            push_byte(p[55-8*i -: 8]);
        end
        push_byte(x ^ 8'h55);
        base = tx_n;
        tx_ok = 1'b1;
        wait_rx(rx_len);
        cycles(40);
        total++;
        if ({gate, camp, ratio, makeup} !== {16'h7FFF, 16'h1234, 5'd1, 16'h0005}
            || tx_n != base) begin
            bad++;
            $display("FAIL csum_bad got %h/%h/%0d/%h tx=%0d want unchanged 0",
                     gate, camp, ratio, makeup, tx_n - base);
        end
        freqs = F1;
        load_pkt(p);
        wait_tx(base + TXN);
        total++;
        if ({gate, camp, ratio, makeup} !== {16'd10, 16'd20, 5'd2, 16'd3}
            || tx_n != base + TXN) begin
            bad++;
            $display("FAIL csum_good got %0d/%0d/%0d/%0d tx=%0d want 10/20/2/3 17",
                     gate, camp, ratio, makeup, tx_n - base);
        end
        check_stream(base, F1, "csum");
    endtask
`endif

    initial begin
        test_reset();
        test_param_load();
        test_tx_stream();
        test_stall();
        test_clamp();
`ifdef RSA_WRAPPER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
